fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_stage_if_id_reg.sv | 31 +++
 rtl/fetch_stage.sv | 134 +++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, instruction field
// positions, FSM state encoding and a word-alignment helper.
package fetch_stage_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 27;
  localparam int unsigned RD_HI  = 26;
  localparam int unsigned RD_LO  = 23;
  localparam int unsigned RN_HI  = 22;
  localparam int unsigned RN_LO  = 19;
  localparam int unsigned RM_HI  = 18;
  localparam int unsigned RM_LO  = 15;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response handshake between fetch and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush (insert NOP bubble) wins over write enable.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (write_en) begin
      instr <= instr_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, FETCH/HOLD/DRAIN FSM and IF/ID register.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_write_en,
  input  logic                 if_id_write_en,
  input  logic                 branch_taken_exmem,
  input  logic [31:0]          branch_target_exmem,
  fetch_stage_if.master        imem,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc,
  output logic                 if_id_valid,
  output logic [4:0]           opcode_ifid,
  output logic [3:0]           Rn_ifid,
  output logic [3:0]           Rm_ifid,
  output logic                 fetch_busy,
  output logic [15:0]          stall_cnt,
  output logic [15:0]          flush_cnt
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  hold_buf;
  logic [31:0]  drain_addr;
  logic [31:0]  pc_plus4;
  logic         advance;
  logic         ifid_load;
  logic [31:0]  ifid_instr_in;

  assign pc_plus4 = pc + 32'd4;
  assign advance  = pc_write_en & if_id_write_en;

  always_comb begin
    ifid_load     = 1'b0;
    ifid_instr_in = imem.imem_rdata;
    case (state)
      FETCH: ifid_load = ~branch_taken_exmem & imem.imem_ready & advance;
      HOLD: begin
        ifid_load     = ~branch_taken_exmem & advance;
        ifid_instr_in = hold_buf;
      end
      default: ifid_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= '0;
      hold_buf   <= '0;
      drain_addr <= '0;
    end else if (branch_taken_exmem) begin
      pc <= align_word(branch_target_exmem);
      case (state)
        FETCH: begin
          // An unanswered request must complete on its original address.
          if (!imem.imem_ready) begin
            state      <= DRAIN;
            drain_addr <= pc;
          end
        end
        HOLD:    state <= FETCH;
        default: state <= DRAIN;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_ready) begin
            if (advance) begin
              pc <= pc_plus4;
            end else begin
              hold_buf <= imem.imem_rdata;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (advance) begin
            pc    <= pc_plus4;
            state <= FETCH;
          end
        end
        default: begin
          if (imem.imem_ready) state <= FETCH;
        end
      endcase
    end
  end

  assign imem.imem_req  = ~rst & (state != HOLD);
  assign imem.imem_addr = (state == DRAIN) ? drain_addr : pc;
  assign fetch_busy     = (state == DRAIN);

  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .write_en (ifid_load),
    .flush    (branch_taken_exmem),
    .instr_in (ifid_instr_in),
    .pc_in    (pc_plus4),
    .instr    (if_id_instr),
    .pc       (if_id_pc),
    .valid    (if_id_valid)
  );

  assign opcode_ifid = if_id_instr[OPC_HI:OPC_LO];
  assign Rn_ifid     = if_id_instr[RN_HI:RN_LO];
  assign Rm_ifid     = if_id_instr[RM_HI:RM_LO];

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!branch_taken_exmem && !if_id_write_en && stall_q != '1) stall_q <= stall_q + 16'd1;
      if (branch_taken_exmem && flush_q != '1) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
